// File: rtl/lia_pkg.sv
// Shared constants and helpers for the lock-in amplifier datapath.
package lia_pkg;

    localparam int DATA_W = 16;
    localparam int POW_W  = 32;

    localparam logic signed [DATA_W-1:0] SAT_MAX = 16'sh7fff;
    localparam logic signed [DATA_W-1:0] SAT_MIN = 16'sh8000;

    typedef enum logic {IDLE, RUN} state_e;

    typedef struct packed {
        logic signed [DATA_W-1:0] val;
        logic                     sat;
    } sat16_t;

    // Out of range exactly when the two top bits of the 17-bit value disagree.
    function automatic sat16_t sat16(input logic signed [DATA_W:0] d);
        sat16_t r;
        r.sat = d[DATA_W] ^ d[DATA_W-1];
        r.val = r.sat ? (d[DATA_W] ? SAT_MIN : SAT_MAX) : d[DATA_W-1:0];
        return r;
    endfunction

    function automatic logic [POW_W-1:0] sq(input logic signed [DATA_W-1:0] x);
        logic signed [POW_W-1:0] x32;
        x32 = {{(POW_W-DATA_W){x[DATA_W-1]}}, x};
        return x32 * x32;
    endfunction

endpackage

// File: rtl/dc_corrected_power_if.sv
// Sample/baseline inputs and corrected/power outputs of dc_corrected_power.
interface dc_corrected_power_if;
    import lia_pkg::*;

    logic                     start;
    logic                     cal_done;
    logic                     in_valid;
    logic signed [DATA_W-1:0] shift05sin, shift05cos, shift6sin, shift6cos;
    logic signed [DATA_W-1:0] base05sin, base05cos, base6sin, base6cos;
    logic signed [DATA_W-1:0] corr05sin, corr05cos, corr6sin, corr6cos;
    logic                     corr_valid;
    logic [POW_W-1:0]         pow05, pow6;
    logic                     pow_valid;
    logic                     win_sat;

    modport master (
        output start, cal_done, in_valid,
        output shift05sin, shift05cos, shift6sin, shift6cos,
        output base05sin, base05cos, base6sin, base6cos,
        input  corr05sin, corr05cos, corr6sin, corr6cos, corr_valid,
        input  pow05, pow6, pow_valid, win_sat
    );

    modport slave (
        input  start, cal_done, in_valid,
        input  shift05sin, shift05cos, shift6sin, shift6cos,
        input  base05sin, base05cos, base6sin, base6cos,
        output corr05sin, corr05cos, corr6sin, corr6cos, corr_valid,
        output pow05, pow6, pow_valid, win_sat
    );

endinterface

// File: rtl/dc_sub_sat.sv
// One channel: registered live-minus-baseline with 16-bit saturation.
module dc_sub_sat
    import lia_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     valid_i,
    input  logic signed [DATA_W-1:0] live_i,
    input  logic signed [DATA_W-1:0] base_i,
    output logic signed [DATA_W-1:0] corr_o,
    output logic                     valid_o,
    output logic                     sat_o
);

    logic signed [DATA_W:0]   diff_d;
    sat16_t                   sat_d;
    logic signed [DATA_W-1:0] corr_q;
    logic                     vld_q;
    logic                     sat_q;

    assign diff_d = {live_i[DATA_W-1], live_i} - {base_i[DATA_W-1], base_i};
    assign sat_d  = sat16(diff_d);

    // corr_q holds its last value across bubbles and flushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            corr_q <= '0;
            vld_q  <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            vld_q <= valid_i && !flush_i;
            if (valid_i && !flush_i) begin
                corr_q <= sat_d.val;
                sat_q  <= sat_d.sat;
            end
        end
    end

    assign corr_o  = corr_q;
    assign valid_o = vld_q;
    assign sat_o   = sat_q;

endmodule

// File: rtl/dc_corrected_power.sv
// Baseline-corrected demod samples, per-frequency I^2+Q^2 and boxcar-averaged power.
module dc_corrected_power
    import lia_pkg::*;
#(
    parameter int AVG_LOG2 = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    dc_corrected_power_if.slave  bus
);

    localparam int NCH   = 4;
    localparam int ACC_W = POW_W + AVG_LOG2;

    state_e state_q, state_d;
    logic   accept, flush;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // start outranks a cal_done drop, which outranks in_valid.
    always_comb begin
        state_d = state_q;
        flush   = bus.start;
        accept  = 1'b0;
        case (state_q)
            IDLE: if (!bus.start && bus.cal_done) state_d = RUN;
            RUN: begin
                if (!bus.start) begin
                    if (!bus.cal_done) begin
                        state_d = IDLE;
                        flush   = 1'b1;
                    end else begin
                        accept = bus.in_valid;
                    end
                end
            end
        endcase
    end

    // Channel order: 0=05sin, 1=05cos, 2=6sin, 3=6cos.
    logic [NCH-1:0][DATA_W-1:0] live, base, corr;
    logic [NCH-1:0]             vld, sat;

    assign live = {bus.shift6cos, bus.shift6sin, bus.shift05cos, bus.shift05sin};
    assign base = {bus.base6cos, bus.base6sin, bus.base05cos, bus.base05sin};

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        dc_sub_sat u_sub (
            .clk     (clk),
            .rst     (rst),
            .flush_i (flush),
            .valid_i (accept),
            .live_i  (live[g]),
            .base_i  (base[g]),
            .corr_o  (corr[g]),
            .valid_o (vld[g]),
            .sat_o   (sat[g])
        );
    end

    logic s1_vld, s1_sat;
    assign s1_vld = &vld;
    assign s1_sat = |sat;

    logic [POW_W-1:0] p05_q, p6_q;
    logic             p_vld_q, p_sat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            p05_q   <= '0;
            p6_q    <= '0;
            p_vld_q <= 1'b0;
            p_sat_q <= 1'b0;
        end else begin
            p_vld_q <= s1_vld && !flush;
            if (s1_vld) begin
                p05_q   <= sq(corr[0]) + sq(corr[1]);
                p6_q    <= sq(corr[2]) + sq(corr[3]);
                p_sat_q <= s1_sat;
            end
        end
    end

    logic [ACC_W-1:0]    acc05_q, acc6_q, sum05_d, sum6_d;
    logic [AVG_LOG2-1:0] cnt_q;
    logic                sticky_q, last_d;
    logic [POW_W-1:0]    pow05_q, pow6_q;
    logic                pow_valid_q, win_sat_q;

    assign sum05_d = acc05_q + ACC_W'(p05_q);
    assign sum6_d  = acc6_q + ACC_W'(p6_q);
    assign last_d  = p_vld_q && (cnt_q == '1);

    // The closing sample is folded into the reported sum; the next sample opens a fresh window.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc05_q     <= '0;
            acc6_q      <= '0;
            cnt_q       <= '0;
            sticky_q    <= 1'b0;
            pow05_q     <= '0;
            pow6_q      <= '0;
            pow_valid_q <= 1'b0;
            win_sat_q   <= 1'b0;
        end else if (flush) begin
            acc05_q     <= '0;
            acc6_q      <= '0;
            cnt_q       <= '0;
            sticky_q    <= 1'b0;
            pow_valid_q <= 1'b0;
        end else begin
            pow_valid_q <= last_d;
            if (p_vld_q) begin
                cnt_q <= cnt_q + AVG_LOG2'(1);
                if (last_d) begin
                    pow05_q   <= sum05_d[AVG_LOG2 +: POW_W];
                    pow6_q    <= sum6_d[AVG_LOG2 +: POW_W];
                    win_sat_q <= sticky_q | p_sat_q;
                    acc05_q   <= '0;
                    acc6_q    <= '0;
                    sticky_q  <= 1'b0;
                end else begin
                    acc05_q  <= sum05_d;
                    acc6_q   <= sum6_d;
                    sticky_q <= sticky_q | p_sat_q;
                end
            end
        end
    end

    assign bus.corr05sin  = corr[0];
    assign bus.corr05cos  = corr[1];
    assign bus.corr6sin   = corr[2];
    assign bus.corr6cos   = corr[3];
    assign bus.corr_valid = s1_vld;
    assign bus.pow05      = pow05_q;
    assign bus.pow6       = pow6_q;
    assign bus.pow_valid  = pow_valid_q;
    assign bus.win_sat    = win_sat_q;

endmodule

// File: tb/tb_dc_corrected_power.sv
// Directed bench for dc_corrected_power: AVG_LOG2=2 main DUT plus an AVG_LOG2=10 reset check.
module tb_dc_corrected_power;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst10 = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   stray;
    logic seen_cv, seen_pv;

    dc_corrected_power_if bus ();
    dc_corrected_power_if bus10 ();

    dc_corrected_power #(.AVG_LOG2(2))  dut   (.clk(clk), .rst(rst),   .bus(bus));
    dc_corrected_power #(.AVG_LOG2(10)) dut10 (.clk(clk), .rst(rst10), .bus(bus10));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic set05(input logic signed [15:0] ssin, input logic signed [15:0] bsin,
                         input logic signed [15:0] scos, input logic signed [15:0] bcos);
        bus.shift05sin = ssin;
        bus.base05sin  = bsin;
        bus.shift05cos = scos;
        bus.base05cos  = bcos;
    endtask

    initial begin
        bus.start = 1'b0; bus.cal_done = 1'b0; bus.in_valid = 1'b0;
        set05(16'sd0, 16'sd0, 16'sd0, 16'sd0);
        bus.shift6sin = 16'sd5000; bus.base6sin = 16'sd5000;
        bus.shift6cos = -16'sd3;   bus.base6cos = -16'sd3;
        bus10.start = 1'b0; bus10.cal_done = 1'b0; bus10.in_valid = 1'b0;
        bus10.shift05sin = 16'sd500; bus10.base05sin = 16'sd0;
        bus10.shift05cos = 16'sd0;   bus10.base05cos = 16'sd0;
        bus10.shift6sin  = 16'sd0;   bus10.base6sin  = 16'sd0;
        bus10.shift6cos  = 16'sd0;   bus10.base6cos  = 16'sd0;
        repeat (2) tick;
        rst = 1'b0;
        tick;
        chk("rst_cv",   bus.corr_valid, 0);
        chk("rst_pv",   bus.pow_valid, 0);
        chk("rst_pow",  bus.pow05, 0);
        chk("rst_corr", bus.corr05sin, 0);
        chk("rst_ws",   bus.win_sat, 0);

        // Reset mid-window on the long-window instance
        bus10.cal_done = 1'b1;
        rst10 = 1'b0;
        tick;
        bus10.in_valid = 1'b1;
        repeat (5) tick;
        chk("r10_pre", bus10.corr05sin, 500);
        rst10 = 1'b1;
        tick;
        chk("r10_corr", bus10.corr05sin, 0);
        chk("r10_cv",   bus10.corr_valid, 0);
        chk("r10_pow",  bus10.pow05, 0);
        chk("r10_pv",   bus10.pow_valid, 0);
        rst10 = 1'b0;
        bus10.in_valid = 1'b0;
        seen_pv = 1'b0;
        repeat (8) begin tick; seen_pv |= bus10.pow_valid; end
        chk("r10_nopv", seen_pv, 0);

        // IDLE gating
        set05(16'sd1000, 16'sd200, 16'sd700, 16'sd100);
        seen_cv = 1'b0; seen_pv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1; tick;
            seen_cv |= bus.corr_valid; seen_pv |= bus.pow_valid;
            bus.in_valid = 1'b0; tick;
            seen_cv |= bus.corr_valid; seen_pv |= bus.pow_valid;
        end
        chk("idle_cv", seen_cv, 0);
        chk("idle_pv", seen_pv, 0);
        bus.cal_done = 1'b1;
        tick;

        // Nominal window: 800^2 + 600^2 = 1000000
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("nom_sin", bus.corr05sin, 800);
            chk("nom_cos", bus.corr05cos, 600);
            chk("nom_cv",  bus.corr_valid, 1);
            chk("nom_6s",  bus.corr6sin, 0);
            chk("nom_pv0", bus.pow_valid, 0);
        end
        bus.in_valid = 1'b0;
        tick;
        chk("nom_pv_early", bus.pow_valid, 0);
        tick;
        chk("nom_pv",  bus.pow_valid, 1);
        chk("nom_p05", bus.pow05, 1000000);
        chk("nom_p6",  bus.pow6, 0);
        chk("nom_ws",  bus.win_sat, 0);
        tick;
        chk("nom_pv_off", bus.pow_valid, 0);
        chk("nom_hold",   bus.pow05, 1000000);

        // Saturated window followed by a clean one: 32767^2 + 32768^2 = 2147418113
        stray = 0;
        for (int i = 1; i <= 12; i++) begin
            bus.in_valid = (i <= 8);
            if (i <= 4) set05(16'sh7fff, 16'sh8000, 16'sh8000, 16'sh7fff);
            else        set05(16'sd1000, 16'sd200, 16'sd700, 16'sd100);
            tick;
            if (i == 1) begin
                chk("sat_sin", bus.corr05sin, 32767);
                chk("sat_cos", bus.corr05cos, -32768);
            end
            if (i == 6) begin
                chk("sat_pv",  bus.pow_valid, 1);
                chk("sat_p05", bus.pow05, 2147418113);
                chk("sat_ws",  bus.win_sat, 1);
            end else if (i == 10) begin
                chk("cln_pv",  bus.pow_valid, 1);
                chk("cln_p05", bus.pow05, 1000000);
                chk("cln_ws",  bus.win_sat, 0);
            end else if (bus.pow_valid) stray++;
        end
        chk("sat_stray", stray, 0);

        // Full negative scale, no clamp: 2 * 2^30
        set05(16'sh8000, 16'sd0, 16'sh8000, 16'sd0);
        stray = 0;
        for (int i = 1; i <= 6; i++) begin
            bus.in_valid = (i <= 4);
            tick;
            if (i == 1) chk("neg_cos", bus.corr05cos, -32768);
            if (i == 6) begin
                chk("neg_pv",  bus.pow_valid, 1);
                chk("neg_p05", bus.pow05, 32'h80000000);
                chk("neg_ws",  bus.win_sat, 0);
            end else if (bus.pow_valid) stray++;
        end
        chk("neg_stray", stray, 0);

        // start mid-window discards two samples; the in_valid alongside start is dropped
        stray = 0;
        for (int i = 1; i <= 9; i++) begin
            bus.in_valid = (i <= 7);
            bus.start    = (i == 3);
            if (i <= 3) set05(16'sd1000, 16'sd200, 16'sd700, 16'sd100);
            else        set05(16'sd2, 16'sd0, 16'sd0, 16'sd0);
            tick;
            if (i == 3) chk("st_cv", bus.corr_valid, 0);
            if (i == 9) begin
                chk("st_pv",  bus.pow_valid, 1);
                chk("st_p05", bus.pow05, 4);
            end else if (bus.pow_valid) stray++;
        end
        bus.start = 1'b0;
        chk("st_stray", stray, 0);

        // cal_done drop after 3 samples, then a fresh window of 20^2 + 15^2 = 625
        stray = 0;
        for (int i = 1; i <= 12; i++) begin
            bus.cal_done = (i != 4);
            bus.in_valid = (i <= 9);
            if (i <= 5) set05(16'sd1000, 16'sd200, 16'sd700, 16'sd100);
            else        set05(16'sd30, 16'sd10, -16'sd5, 16'sd10);
            tick;
            if (i == 5) begin
                chk("drop_corr", bus.corr05sin, 800);
                chk("drop_cv",   bus.corr_valid, 0);
            end
            if (i == 10) chk("drop_hold", bus.pow05, 4);
            if (i == 11) begin
                chk("drop_pv",  bus.pow_valid, 1);
                chk("drop_p05", bus.pow05, 625);
                chk("drop_p6",  bus.pow6, 0);
            end else if (bus.pow_valid) stray++;
        end
        chk("drop_stray", stray, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
